uart_tx_arbiter: RTL and testbench

//   Shares the single uart_tx byte channel between NUM_REQ byte-stream requesters,
//   e.g. the JTAG-driven printf string sender and the uart_rx echo path.

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester-side and uart_tx-side byte handshake bundle.
// Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_data_valid;
  logic                 tx_data_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;

  modport master (
    output req_valid, req_data, req_last, tx_data_ready,
    input  req_ready, tx_data, tx_data_valid, grant, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_data_ready,
    output req_ready, tx_data, tx_data_valid, grant, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-granular round-robin sharing of the uart_tx byte channel.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int GAP_TIMEOUT = 1024,
  parameter int GAP_W       = 11
) (
  input wire               sys_clk,
  input wire               sys_rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [c_PTR_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic [GAP_W-1:0]     r_gap_cnt, w_gap_nxt;
  logic [c_PTR_W-1:0]   w_owner;
  logic                 w_owner_valid;
  logic                 w_owner_last;
  logic                 w_release;
  logic [7:0]           w_tx_data;

  // First valid requester at or after ptr, wrapping to the lowest index otherwise.
  function automatic logic [NUM_REQ-1:0] f_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [c_PTR_W-1:0] ptr);
    logic [NUM_REQ-1:0] sel_hi;
    logic [NUM_REQ-1:0] sel_any;
    logic               hi_found;
    sel_hi   = '0;
    sel_any  = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        sel_any    = '0;
        sel_any[i] = 1'b1;
        if (i >= int'(ptr)) begin
          sel_hi    = '0;
          sel_hi[i] = 1'b1;
          hi_found  = 1'b1;
        end
      end
    end
    return hi_found ? sel_hi : sel_any;
  endfunction

  function automatic logic [c_PTR_W-1:0] f_index(input logic [NUM_REQ-1:0] onehot);
    logic [c_PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (onehot[i]) idx = c_PTR_W'(i);
    end
    return idx;
  endfunction

  assign w_owner       = f_index(r_grant);
  assign w_owner_valid = |(r_grant & bus.req_valid);
  assign w_owner_last  = |(r_grant & bus.req_last);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_gap_nxt   = r_gap_cnt;
    w_release   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          w_grant_nxt = f_pick(bus.req_valid, r_rr_ptr);
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        // A held byte keeps the stall timer cleared even while uart_tx is busy.
        if (w_owner_valid) begin
          w_gap_nxt = '0;
          w_release = bus.tx_data_ready & w_owner_last;
        end else if (r_gap_cnt == GAP_W'(GAP_TIMEOUT - 1)) begin
          w_release = 1'b1;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_gap_nxt   = '0;
          w_rr_nxt    = (w_owner == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_owner + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_tx_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_tx_data = w_tx_data | bus.req_data[8*i +: 8];
    end
  end

  assign bus.tx_data       = w_tx_data;
  assign bus.tx_data_valid = w_owner_valid;
  assign bus.req_ready     = r_grant & bus.req_valid & {NUM_REQ{bus.tx_data_ready}};
  assign bus.grant         = r_grant;
  assign bus.busy          = (r_state == S_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed and randomized self-checking bench for uart_tx_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;
  localparam int NUM_REQ     = 2;
  localparam int GAP_TIMEOUT = 16;
  localparam int GAP_W       = 5;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .GAP_TIMEOUT(GAP_TIMEOUT),
    .GAP_W      (GAP_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Requester byte streams and the expected uart_tx byte order.
  logic [7:0] dmem [NUM_REQ][64];
  bit         lmem [NUM_REQ][64];
  int         cnt  [NUM_REQ];
  int         pos  [NUM_REQ];
  logic [7:0] exp_b [$];
  int         exp_r [$];
  int         xcyc  [$];
  bit         stable;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < NUM_REQ; r++) begin
      cnt[r] = 0;
      pos[r] = 0;
    end
    exp_b.delete();
    exp_r.delete();
    xcyc.delete();
  endtask

  task automatic add_byte(input int r, input logic [7:0] b, input bit last);
    dmem[r][cnt[r]] = b;
    lmem[r][cnt[r]] = last;
    cnt[r]++;
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.req_valid[r]       = (pos[r] < cnt[r]);
      bus.req_data[8*r +: 8] = (pos[r] < cnt[r]) ? dmem[r][pos[r]] : 8'h00;
      bus.req_last[r]        = (pos[r] < cnt[r]) ? lmem[r][pos[r]] : 1'b0;
    end
  endtask

  task automatic do_reset();
    sys_rst_n         = 1'b0;
    bus.req_valid     = '0;
    bus.req_data      = '0;
    bus.req_last      = '0;
    bus.tx_data_ready = 1'b0;
    clear_model();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  // mode 0: ready tied high, 1: one-cycle pulse every 10 cycles, 2: random
  task automatic pump(input int mode, input int max_cyc);
    int got;
    int cyc;
    logic [NUM_REQ-1:0] adv;
    got = 0;
    cyc = 0;
    while (got < exp_b.size() && cyc < max_cyc) begin
      drive_reqs();
      case (mode)
        0:       bus.tx_data_ready = 1'b1;
        1:       bus.tx_data_ready = (cyc % 10 == 9);
        default: bus.tx_data_ready = ($urandom_range(0, 3) != 0);
      endcase
      #4;
      if (bus.tx_data_valid && bus.tx_data_ready) begin
        check("xfer_data", 32'(bus.tx_data), 32'(exp_b[got]));
        check("xfer_owner", 32'(bus.grant), 32'(1) << exp_r[got]);
        check("xfer_ready", 32'(bus.req_ready), 32'(1) << exp_r[got]);
        xcyc.push_back(cyc);
        got++;
      end else begin
        check("idle_ready", 32'(bus.req_ready), 32'd0);
      end
      adv = bus.req_ready;
      tick();
      for (int r = 0; r < NUM_REQ; r++) begin
        if (adv[r]) pos[r]++;
      end
      cyc++;
    end
    check("stream_done", 32'(got), 32'(exp_b.size()));
    drive_reqs();
    bus.tx_data_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] hi [4];
    int len;
    logic [7:0] b;
    hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0d; hi[3] = 8'h0a;

    // Reset values before any clock edge
    bus.req_valid     = '0;
    bus.req_data      = '0;
    bus.req_last      = '0;
    bus.tx_data_ready = 1'b0;
    #3;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_txv", 32'(bus.tx_data_valid), 32'd0);
    check("rst_txd", 32'(bus.tx_data), 32'd0);
    check("rst_rdy", 32'(bus.req_ready), 32'd0);

    // "Hi\r\n" from requester 0 with sparse ready pulses
    do_reset();
    for (int k = 0; k < 4; k++) begin
      add_byte(0, hi[k], k == 3);
      exp_b.push_back(hi[k]);
      exp_r.push_back(0);
    end
    pump(1, 200);
    check("t1_grant_after", 32'(bus.grant), 32'd0);
    check("t1_busy_after", 32'(bus.busy), 32'd0);

    // Two 3-byte packets contending from reset
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        add_byte(r, 8'(16 * (r + 1) + k), k == 2);
        exp_b.push_back(8'(16 * (r + 1) + k));
        exp_r.push_back(r);
      end
    end
    pump(0, 100);
    check("t2_first_lat", 32'(xcyc[0]), 32'd1);
    check("t2_burst0", 32'(xcyc[2] - xcyc[0]), 32'd2);
    check("t2_idle_gap", 32'(xcyc[3] - xcyc[2]), 32'd2);

    // Single-byte packets alternate with one idle cycle between grants
    do_reset();
    for (int p = 0; p < 4; p++) begin
      add_byte(0, 8'hA5, 1'b1);
      add_byte(1, 8'h5A, 1'b1);
      exp_b.push_back(8'hA5); exp_r.push_back(0);
      exp_b.push_back(8'h5A); exp_r.push_back(1);
    end
    pump(0, 100);
    for (int k = 1; k < 8; k++) begin
      check("t3_spacing", 32'(xcyc[k] - xcyc[k-1]), 32'd2);
    end

    // Stalled owner is revoked after GAP_TIMEOUT idle cycles
    do_reset();
    bus.req_valid = 2'b10; bus.req_data = 16'h1100; bus.req_last = 2'b00;
    bus.tx_data_ready = 1'b1;
    tick(); #4;
    check("t4_grant", 32'(bus.grant), 32'h2);
    check("t4_byte", 32'(bus.tx_data), 32'h11);
    check("t4_rdy", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b01; bus.req_data = 16'h0022; bus.req_last = 2'b01;
    #4;
    check("t4_hold_grant", 32'(bus.grant), 32'h2);
    check("t4_nonowner_rdy", 32'(bus.req_ready), 32'h0);
    check("t4_no_valid", 32'(bus.tx_data_valid), 32'h0);
    repeat (15) tick();
    #4;
    check("t4_last_idle_grant", 32'(bus.grant), 32'h2);
    check("t4_last_idle_busy", 32'(bus.busy), 32'h1);
    tick(); #4;
    check("t4_revoked", 32'(bus.grant), 32'h0);
    check("t4_revoked_busy", 32'(bus.busy), 32'h0);
    tick(); #4;
    check("t4_next_grant", 32'(bus.grant), 32'h1);
    check("t4_next_byte", 32'(bus.tx_data), 32'h22);
    tick();
    bus.req_valid = '0; bus.req_last = '0;

    // Asynchronous reset mid-packet; arbitration restarts at requester 0
    do_reset();
    bus.req_valid = 2'b01; bus.req_data = 16'h00C0; bus.req_last = 2'b01;
    bus.tx_data_ready = 1'b1;
    tick(); #4;
    check("t5_c0", 32'(bus.tx_data), 32'hC0);
    tick();
    bus.req_data = 16'h00D0; bus.req_last = 2'b00;
    tick(); #4;
    check("t5_d0", 32'(bus.tx_data), 32'hD0);
    tick();
    bus.req_data = 16'h00D1; #4;
    check("t5_d1", 32'(bus.tx_data), 32'hD1);
    tick();
    bus.req_data = 16'h00D2; #4;
    check("t5_pre_rst_valid", 32'(bus.tx_data_valid), 32'h1);
    sys_rst_n = 1'b0;
    #1;
    check("t5_rst_txv", 32'(bus.tx_data_valid), 32'h0);
    check("t5_rst_rdy", 32'(bus.req_ready), 32'h0);
    check("t5_rst_grant", 32'(bus.grant), 32'h0);
    bus.req_valid = 2'b11; bus.req_data = 16'hE1D2; bus.req_last = 2'b10;
    repeat (3) begin
      tick();
      check("t5_in_rst_txv", 32'(bus.tx_data_valid), 32'h0);
    end
    sys_rst_n = 1'b1;
    tick(); #4;
    check("t5_restart_grant", 32'(bus.grant), 32'h1);
    check("t5_restart_byte", 32'(bus.tx_data), 32'hD2);
    tick();
    bus.req_valid = '0; bus.req_last = '0;

    // Long uart_tx back-pressure must not time out the owner
    do_reset();
    bus.req_valid = 2'b01; bus.req_data = 16'h003C; bus.req_last = 2'b01;
    bus.tx_data_ready = 1'b0;
    tick(); #4;
    check("t6_grant", 32'(bus.grant), 32'h1);
    check("t6_valid", 32'(bus.tx_data_valid), 32'h1);
    stable = 1'b1;
    repeat (200) begin
      tick();
      if (bus.tx_data !== 8'h3C || bus.req_ready !== 2'b00 || bus.grant !== 2'b01)
        stable = 1'b0;
    end
    check("t6_stable", 32'(stable), 32'h1);
    bus.tx_data_ready = 1'b1; #4;
    check("t6_rdy", 32'(bus.req_ready), 32'h1);
    tick();
    check("t6_release", 32'(bus.grant), 32'h0);
    bus.req_valid = '0; bus.req_last = '0; bus.tx_data_ready = 1'b0;

    // Random packets from both requesters, all continuously active: strict rotation
    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        len = int'($urandom_range(1, 4));
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          add_byte(r, b, k == len - 1);
          exp_b.push_back(b);
          exp_r.push_back(r);
        end
      end
    end
    pump(2, 1000);
    check("rand_idle_end", 32'(bus.grant), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
